dual_address_ram_bist: RTL and testbench
========================================

# dual_address_ram_bist

Built-in self-test sequencer that drives the 16x8 dual_address_ram as its initiator. It fills the array through write port 0 with an address-derived pattern, then reads every word back through read port 1. It compares each read against the expected value and reports pass/fail, error count and first failing address. It sits beside the RAM, and its RAM-side ports connect one-to-one to the RAM's ports of the same name.

## Interface
- DATA_W, 8, RAM word width
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W
- clk  in  1  rising-edge clock shared with the RAM
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request; sampled in IDLE or DONE only
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  high in DONE; held until the next start or reset
- pass  out  1  valid while done; 1 iff err_count == 0
- err_count  out  ADDR_W+1  mismatches counted; saturates at all-ones
- fail_addr  out  ADDR_W  address of first mismatch; 0 if none
- port_en_0  out  1  RAM port 0 enable
- wr_en  out  1  RAM write enable
- addr_in_0  out  ADDR_W  RAM write address
- data_in  out  DATA_W  RAM write data
- port_en_1  out  1  RAM port 1 enable
- addr_in_1  out  ADDR_W  RAM read address
- data_out_1  in  DATA_W  RAM port 1 read data; registered by the RAM one edge after address/enable

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE; plus WRITE_INV and READ_INV under the configuration macro.
- IDLE / DONE, start=1 -> WRITE. The transition clears err_count, fail_addr, pass and done, and zeroes the address counter.
- WRITE: port_en_0=1, wr_en=1, addr_in_0=cnt, data_in=pattern(cnt), cnt 0..15, one word per cycle. cnt=15 -> READ, cnt wraps to 0.
- READ: port_en_1=1, addr_in_1=cnt, cnt 0..15. A 2-stage expected-value/valid pipeline tracks each read. The compare occurs at the second edge after the address is presented. cnt=15 -> DRAIN.
- DRAIN: 2 cycles, so the last two compares retire -> DONE.
- pattern(a) = (a + 1) truncated to DATA_W, so addr 0 -> 0x01 and addr 15 -> 0x10.
- On mismatch:
  - err_count increments, saturating at 2**(ADDR_W+1)-1.
  - On the first mismatch only, fail_addr latches that address.
- All RAM-side outputs and status outputs are registered.
- All enables are 0 outside WRITE and READ states; addresses and data are 0 when their port is idle.
- start is ignored while busy.
- Reset, async, at any time including mid-test: state IDLE; all outputs 0; pipeline valid bits cleared. An in-progress test is abandoned with no done pulse.

## Timing
- Edges are numbered from the edge that samples start (edge 0).
- busy rises after edge 0.
- Writes to addr i commit in the RAM at edge i+1 (edges 1..16).
- Read addr i is presented after edge 16+i, the RAM registers it at 17+i, and the compare happens at 18+i (last compare at edge 33).
- done, pass and final err_count become visible after edge 34; busy falls at the same edge.
- Test latency is 34 cycles base, 66 with the macro.
- The read of addr 15 is registered by the RAM before any subsequent write (relevant to the macro pass).

## Configuration
- DUAL_RAM_BIST_INVERT_PASS_EN defined:
  - READ -> WRITE_INV at edge 32.
  - WRITE_INV and READ_INV repeat WRITE/READ using pattern ~(a+1), e.g. addr 0 -> 0xFE.
  - READ_INV -> DRAIN -> DONE, with done after edge 66.
  - Errors from both passes accumulate; the maximum count of 32 saturates at 31.
- DUAL_RAM_BIST_INVERT_PASS_EN undefined: single pass only. The WRITE_INV and READ_INV states and their logic are absent.

## Test plan
- Reset 2 cycles, then a start pulse with a correct RAM attached -> 16 writes of 0x01..0x10 at addresses 0..15 on edges 1..16; done=1, pass=1, err_count=0, fail_addr=0 after edge 34.
- RAM model returns 0x00 for address 5 and 0xFF for address 9 -> pass=0, err_count=2, fail_addr=5.
- start re-pulsed at edge 10 while busy -> ignored, done still at edge 34. start in DONE -> done and err_count clear at the next edge and a full test reruns.
- rst asserted asynchronously mid-WRITE (between edges 8 and 9) -> all outputs 0 immediately, state IDLE. A later start completes normally with pass=1.
- Macro defined, correct RAM -> second pass writes 0xFE..0xEF, done after edge 66, pass=1.
- Macro defined, data_out_1 stuck at 0x00 -> err_count saturates at 31, fail_addr=0, pass=0.

Source files
------------

// File: rtl/dual_address_ram_bist_if.sv
// RAM-side bus between the BIST sequencer (master) and the 16x8 dual_address_ram (slave).
// Signal names match the RAM's own port names so the hookup is one-to-one.
interface dual_address_ram_bist_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) ();
  logic              port_en_0;
  logic              wr_en;
  logic [ADDR_W-1:0] addr_in_0;
  logic [DATA_W-1:0] data_in;
  logic              port_en_1;
  logic [ADDR_W-1:0] addr_in_1;
  logic [DATA_W-1:0] data_out_1;

  modport master (
    output port_en_0, wr_en, addr_in_0, data_in, port_en_1, addr_in_1,
    input  data_out_1
  );

  modport slave (
    input  port_en_0, wr_en, addr_in_0, data_in, port_en_1, addr_in_1,
    output data_out_1
  );
endinterface

// File: rtl/dual_address_ram_bist.sv
// BIST sequencer: fills the RAM with (addr+1), reads it back and reports pass/err_count/fail_addr.
// Define DUAL_RAM_BIST_INVERT_PASS_EN to add a second pass using the inverted pattern ~(addr+1).
module dual_address_ram_bist #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_W:0]       err_count,
  output logic [ADDR_W-1:0]     fail_addr,
  dual_address_ram_bist_if.master ram
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WRITE     = 3'd1;
  localparam logic [2:0] S_READ      = 3'd2;
  localparam logic [2:0] S_DRAIN     = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
`ifdef DUAL_RAM_BIST_INVERT_PASS_EN
  localparam logic [2:0] S_WRITE_INV = 3'd5;
  localparam logic [2:0] S_READ_INV  = 3'd6;
`endif

  localparam logic [ADDR_W-1:0] CNT_MAX    = '1;
  localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_inc;
  logic [DATA_W-1:0] exp0;
  logic [DATA_W-1:0] exp1;
  logic [ADDR_W-1:0] addr1;
  logic              vld1;

  assign cnt_inc = cnt + 1'b1;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic inv);
    logic [DATA_W-1:0] p;
    p = DATA_W'(a) + DATA_W'(1);
    return inv ? ~p : p;
  endfunction

  // Read pipeline: stage 0 is the registered read request (port_en_1/addr_in_1/exp0),
  // stage 1 lines up with the RAM's registered data_out_1, where the compare happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      fail_addr     <= '0;
      ram.port_en_0 <= 1'b0;
      ram.wr_en     <= 1'b0;
      ram.addr_in_0 <= '0;
      ram.data_in   <= '0;
      ram.port_en_1 <= 1'b0;
      ram.addr_in_1 <= '0;
      exp0          <= '0;
      exp1          <= '0;
      addr1         <= '0;
      vld1          <= 1'b0;
    end else begin
      ram.port_en_0 <= 1'b0;
      ram.wr_en     <= 1'b0;
      ram.addr_in_0 <= '0;
      ram.data_in   <= '0;
      ram.port_en_1 <= 1'b0;
      ram.addr_in_1 <= '0;
      exp0          <= '0;

      vld1  <= ram.port_en_1;
      exp1  <= exp0;
      addr1 <= ram.addr_in_1;

      if (vld1 && (ram.data_out_1 != exp1)) begin
        if (err_count != '1)
          err_count <= err_count + 1'b1;
        if (err_count == '0)
          fail_addr <= addr1;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_WRITE;
            cnt           <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            fail_addr     <= '0;
            ram.port_en_0 <= 1'b1;
            ram.wr_en     <= 1'b1;
            ram.data_in   <= pattern('0, 1'b0);
          end
        end

        S_WRITE: begin
          cnt <= cnt_inc;
          if (cnt == CNT_MAX) begin
            state         <= S_READ;
            ram.port_en_1 <= 1'b1;
            exp0          <= pattern('0, 1'b0);
          end else begin
            ram.port_en_0 <= 1'b1;
            ram.wr_en     <= 1'b1;
            ram.addr_in_0 <= cnt_inc;
            ram.data_in   <= pattern(cnt_inc, 1'b0);
          end
        end

        S_READ: begin
          cnt <= cnt_inc;
          if (cnt == CNT_MAX) begin
`ifdef DUAL_RAM_BIST_INVERT_PASS_EN
            state         <= S_WRITE_INV;
            ram.port_en_0 <= 1'b1;
            ram.wr_en     <= 1'b1;
            ram.data_in   <= pattern('0, 1'b1);
`else
            state         <= S_DRAIN;
`endif
          end else begin
            ram.port_en_1 <= 1'b1;
            ram.addr_in_1 <= cnt_inc;
            exp0          <= pattern(cnt_inc, 1'b0);
          end
        end

`ifdef DUAL_RAM_BIST_INVERT_PASS_EN
        S_WRITE_INV: begin
          cnt <= cnt_inc;
          if (cnt == CNT_MAX) begin
            state         <= S_READ_INV;
            ram.port_en_1 <= 1'b1;
            exp0          <= pattern('0, 1'b1);
          end else begin
            ram.port_en_0 <= 1'b1;
            ram.wr_en     <= 1'b1;
            ram.addr_in_0 <= cnt_inc;
            ram.data_in   <= pattern(cnt_inc, 1'b1);
          end
        end

        S_READ_INV: begin
          cnt <= cnt_inc;
          if (cnt == CNT_MAX) begin
            state <= S_DRAIN;
          end else begin
            ram.port_en_1 <= 1'b1;
            ram.addr_in_1 <= cnt_inc;
            exp0          <= pattern(cnt_inc, 1'b1);
          end
        end
`endif

        // Two idle cycles let the last two in-flight reads reach the compare stage.
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= S_DONE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0);
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_address_ram_bist.sv
// Randomized self-checking bench for dual_address_ram_bist with a fault-injecting RAM model.
// Expected bus activity and final status come from an edge-indexed schedule and a fault-table model.
module tb_dual_address_ram_bist;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
`ifdef DUAL_RAM_BIST_INVERT_PASS_EN
  localparam int NPASS = 2;
  localparam int LAT   = 66;
`else
  localparam int NPASS = 1;
  localparam int LAT   = 34;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] fail_addr;

  dual_address_ram_bist_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dual_address_ram_bist #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .ram       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  bit active = 1'b0;

  logic [DW-1:0]    mem [DEPTH];
  bit   [DEPTH-1:0] fault_en;
  logic [DW-1:0]    fault_val [DEPTH];

  int m_err;
  int m_fail;
  int m_pass;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read, faulty addresses return their forced value
  always @(posedge clk) begin
    if (bus.port_en_0 && bus.wr_en)
      mem[bus.addr_in_0] <= bus.data_in;
    if (bus.port_en_1)
      bus.data_out_1 <= fault_en[bus.addr_in_1] ? fault_val[bus.addr_in_1] : mem[bus.addr_in_1];
  end

  function automatic logic [DW-1:0] pat(input int a, input bit inv);
    logic [DW-1:0] p;
    p = 8'(a + 1);
    return inv ? ~p : p;
  endfunction

  // Bus image {port_en_0, wr_en, addr_in_0, data_in, port_en_1, addr_in_1} after edge e
  function automatic logic [18:0] busImage(input int e);
    logic [18:0] r;
    int a;
    int phase;
    r = '0;
    if (e >= 0 && e < 32 * NPASS) begin
      a = e % 16;
      phase = e / 16;
      if (phase % 2 == 0)
        r = {1'b1, 1'b1, 4'(a), pat(a, phase >= 2), 1'b0, 4'b0};
      else
        r = {1'b0, 1'b0, 4'b0, 8'b0, 1'b1, 4'(a)};
    end
    return r;
  endfunction

  task automatic computeModel();
    logic [DW-1:0] ev;
    m_err = 0;
    m_fail = 0;
    for (int p = 0; p < NPASS; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        ev = pat(a, p == 1);
        if (fault_en[a] && fault_val[a] != ev) begin
          if (m_err == 0) m_fail = a;
          if (m_err < 31) m_err++;
        end
      end
    end
    m_pass = (m_err == 0) ? 1 : 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkResetZero(input string name);
    checkOutput({name, "_status"}, {27'b0, busy, done, pass, err_count, fail_addr}, 32'h0);
    checkOutput({name, "_bus"}, {13'b0, bus.port_en_0, bus.wr_en, bus.addr_in_0, bus.data_in,
                                 bus.port_en_1, bus.addr_in_1}, 32'h0);
  endtask

  task automatic clearFaults();
    fault_en = '0;
    for (int a = 0; a < DEPTH; a++) fault_val[a] = '0;
  endtask

  // Pulse start, then follow the run; optional re-pulse while busy or async reset mid-run
  task automatic applyStimulus(input int restart_edge, input int abort_edge);
    int e;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
    computeModel();
    active = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      e = cyc - start_cyc;
      if (e == abort_edge) begin
        active = 1'b0;
        rst = 1'b1;
        #1;
        checkResetZero("async_reset");
        repeat (2) @(negedge clk);
        checkResetZero("reset_hold");
        rst = 1'b0;
        return;
      end
      start = (e == restart_edge - 1);
    end
    start = 1'b0;
  endtask

  // Per-cycle compare of bus and status against the schedule and fault model
  always @(negedge clk) begin : compare_proc
    int e;
    logic [18:0] act_bus;
    if (active) begin
      e = cyc - start_cyc;
      act_bus = {bus.port_en_0, bus.wr_en, bus.addr_in_0, bus.data_in, bus.port_en_1, bus.addr_in_1};
      checkOutput("ram_bus", 32'(act_bus), 32'(busImage(e)));
      checkOutput("busy", 32'(busy), 32'(e < LAT));
      checkOutput("done", 32'(done), 32'(e >= LAT));
      if (e >= LAT) begin
        checkOutput("err_count", 32'(err_count), m_err);
        checkOutput("fail_addr", 32'(fail_addr), m_fail);
        checkOutput("pass", 32'(pass), m_pass);
      end else begin
        checkOutput("pass_low", 32'(pass), 32'h0);
        if (e <= 17)
          checkOutput("status_clear", 32'({err_count, fail_addr}), 32'h0);
      end
      if (e == 0)  checkOutput("lit_first_write", 32'(bus.data_in), 32'h01);
      if (e == 15) checkOutput("lit_last_write", 32'(bus.data_in), 32'h10);
`ifdef DUAL_RAM_BIST_INVERT_PASS_EN
      if (e == 32) checkOutput("lit_inv_first", 32'(bus.data_in), 32'hFE);
      if (e == 47) checkOutput("lit_inv_last", 32'(bus.data_in), 32'hEF);
`endif
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    clearFaults();
    repeat (2) @(negedge clk);
    checkResetZero("reset");
    rst = 1'b0;

    $display("[TB] clean run");
    applyStimulus(-1, -1);
    checkOutput("lit_clean_pass", 32'(pass), 32'h1);
    checkOutput("lit_clean_err", 32'(err_count), 32'h0);

    $display("[TB] faults at 5 and 9, start re-pulsed at edge 10");
    fault_en[5] = 1'b1; fault_val[5] = 8'h00;
    fault_en[9] = 1'b1; fault_val[9] = 8'hFF;
    applyStimulus(10, -1);
`ifdef DUAL_RAM_BIST_INVERT_PASS_EN
    checkOutput("lit_fault_err", 32'(err_count), 32'h4);
`else
    checkOutput("lit_fault_err", 32'(err_count), 32'h2);
`endif
    checkOutput("lit_fault_addr", 32'(fail_addr), 32'h5);
    checkOutput("lit_fault_pass", 32'(pass), 32'h0);

    $display("[TB] restart from DONE with clean RAM");
    clearFaults();
    applyStimulus(-1, -1);
    checkOutput("lit_rerun_pass", 32'(pass), 32'h1);

    $display("[TB] async reset mid-write");
    applyStimulus(-1, 8);
    applyStimulus(-1, -1);
    checkOutput("lit_after_reset_pass", 32'(pass), 32'h1);

    $display("[TB] read data stuck at zero");
    fault_en = '1;
    applyStimulus(-1, -1);
`ifdef DUAL_RAM_BIST_INVERT_PASS_EN
    checkOutput("lit_stuck_err", 32'(err_count), 32'd31);
`else
    checkOutput("lit_stuck_err", 32'(err_count), 32'd16);
`endif
    checkOutput("lit_stuck_addr", 32'(fail_addr), 32'h0);
    checkOutput("lit_stuck_pass", 32'(pass), 32'h0);

    $display("[TB] randomized fault runs");
    for (int r = 0; r < 8; r++) begin
      clearFaults();
      for (int a = 0; a < DEPTH; a++) begin
        fault_en[a]  = ($urandom_range(0, 3) == 0);
        fault_val[a] = 8'($urandom);
      end
      applyStimulus(($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, LAT - 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
